// File: rtl/mem_write_checker.sv
// Purpose: snoops the data-memory write port and decides pass/fail against N expected writes.
// Latency: 1 edge from a sampled write to every output; all outputs are registered.
// Backpressure: none; passive observer that never stalls or throttles the write port.
//
// Ports: clk, reset (async, active-low); MemWrite/Adr/WriteData snooped write port;
//   exp_adr/exp_data packed expected writes (entry i at [i*W +: W]); ign_adr tolerated addresses;
//   done/pass/fail status flags; fail_code (1 adr, 2 data, 3 dup, 4 timeout);
//   match_cnt matched so far; err_adr/err_data capture the failing write (0 on timeout).
module mem_write_checker #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int N_EXP   = 4,
  parameter int N_IGN   = 2,
  parameter bit ORDERED = 1'b1,
  parameter int TIMEOUT = 4096,
  localparam int CNT_W  = $clog2(N_EXP + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    MemWrite,
  input  logic [ADDR_W-1:0]       Adr,
  input  logic [DATA_W-1:0]       WriteData,
  input  logic [N_EXP*ADDR_W-1:0] exp_adr,
  input  logic [N_EXP*DATA_W-1:0] exp_data,
  input  logic [N_IGN*ADDR_W-1:0] ign_adr,
  output logic                    done,
  output logic                    pass,
  output logic                    fail,
  output logic [2:0]              fail_code,
  output logic [CNT_W-1:0]        match_cnt,
  output logic [ADDR_W-1:0]       err_adr,
  output logic [DATA_W-1:0]       err_data
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_EXP - 1);

  localparam logic [2:0] CODE_ADR  = 3'd1;
  localparam logic [2:0] CODE_DATA = 3'd2;
  localparam logic [2:0] CODE_DUP  = 3'd3;
  localparam logic [2:0] CODE_TMO  = 3'd4;

  typedef enum logic [1:0] {stRun, stPass, stFail} state_t;

  state_t             state;
  logic [N_EXP-1:0]   matchMap;
  logic [TMR_W-1:0]   cycCnt;

  logic [N_EXP-1:0]   adrVec;
  logic [N_EXP-1:0]   hitVec;
  logic [N_EXP-1:0]   curOneHot;
  logic [N_EXP-1:0]   unmatchedHit;
  logic [N_EXP-1:0]   newBit;
  logic               isIgn;
  logic               isHit;
  logic               isDup;
  logic               isDataMis;
  logic               isTmo;
  logic [2:0]         wrCode;

  // Per-entry address and address+data comparisons, plus the tolerated-address check.
  always_comb begin
    adrVec = '0;
    hitVec = '0;
    isIgn  = 1'b0;
    for (int i = 0; i < N_EXP; i++) begin
      adrVec[i] = (Adr == exp_adr[i*ADDR_W +: ADDR_W]);
      hitVec[i] = adrVec[i] && (WriteData == exp_data[i*DATA_W +: DATA_W]);
    end
    for (int j = 0; j < N_IGN; j++) begin
      if (Adr == ign_adr[j*ADDR_W +: ADDR_W]) isIgn = 1'b1;
    end
  end

  // Classification. newBit is the single bitmap bit a hit would set: the entry at
  // match_cnt when ordered, otherwise the lowest unmatched entry that fully matches.
  always_comb begin
    curOneHot = '0;
    for (int i = 0; i < N_EXP; i++) begin
      if (match_cnt == CNT_W'(i)) curOneHot[i] = 1'b1;
    end
    unmatchedHit = hitVec & ~matchMap;
    if (ORDERED) begin
      newBit    = hitVec & curOneHot;
      isDup     = 1'b0;
      isDataMis = |(adrVec & curOneHot);
    end else begin
      newBit    = unmatchedHit & (~unmatchedHit + N_EXP'(1));
      isDup     = |(hitVec & matchMap);
      isDataMis = |(adrVec & ~matchMap);
    end
    isHit = |newBit;
    isTmo = (cycCnt == TMO_LAST);
    // Only consulted when the write is neither a hit nor ignored.
    if (isDup)          wrCode = CODE_DUP;
    else if (isDataMis) wrCode = CODE_DATA;
    else                wrCode = CODE_ADR;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= stRun;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_code <= 3'd0;
      match_cnt <= '0;
      err_adr   <= '0;
      err_data  <= '0;
      matchMap  <= '0;
      cycCnt    <= '0;
    end else if (state == stRun) begin
      if (!isTmo) cycCnt <= cycCnt + TMR_W'(1);
      if (MemWrite && isHit) begin
        matchMap  <= matchMap | newBit;
        match_cnt <= match_cnt + CNT_W'(1);
        // The final expected write beats a coincident timeout.
        if (match_cnt == CNT_LAST) begin
          state <= stPass;
          pass  <= 1'b1;
          done  <= 1'b1;
        end else if (isTmo) begin
          state     <= stFail;
          fail      <= 1'b1;
          done      <= 1'b1;
          fail_code <= CODE_TMO;
        end
      end else if (MemWrite && !isIgn) begin
        state     <= stFail;
        fail      <= 1'b1;
        done      <= 1'b1;
        fail_code <= wrCode;
        err_adr   <= Adr;
        err_data  <= WriteData;
      end else if (isTmo) begin
        state     <= stFail;
        fail      <= 1'b1;
        done      <= 1'b1;
        fail_code <= CODE_TMO;
      end
    end
  end

endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Synthesisable, parametrised write-sequence checker that snoops the processor's data-memory write port (MemWrite, Adr, WriteData) and decides pass/fail on its own. It generalises the single-address success/failure check to N expected writes, a list of tolerated addresses, ordered or unordered matching, and a cycle timeout. It sits beside `top` in simulation and FPGA bring-up and drives status LEDs or bench `$stop` logic from registered flags.

## Interface
- `ADDR_W`, 32, width of the snooped address.
- `DATA_W`, 32, width of the snooped write data.
- `N_EXP`, 4, number of expected writes (≥1).
- `N_IGN`, 2, number of tolerated addresses (≥1). Writes to these never fail.
- `ORDERED`, 1, 1 = expected writes must occur in index order; 0 = any order.
- `TIMEOUT`, 4096, cycles allowed in RUN before timeout failure (≥2).
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-low. Asserted when 0.
- `MemWrite` in 1: write strobe, sampled on the rising edge.
- `Adr` in ADDR_W: write address.
- `WriteData` in DATA_W: write data.
- `exp_adr` in N_EXP*ADDR_W: expected addresses; entry i is at bits [i*ADDR_W +: ADDR_W].
- `exp_data` in N_EXP*DATA_W: expected data, packed the same way.
- `ign_adr` in N_IGN*ADDR_W: tolerated addresses. Must be static while running.
- `done` out 1: PASS or FAIL reached.
- `pass` out 1: all expected writes matched.
- `fail` out 1: check failed.
- `fail_code` out 3: 0 none, 1 unexpected address, 2 data mismatch, 3 duplicate, 4 timeout.
- `match_cnt` out $clog2(N_EXP+1): expected writes matched so far.
- `err_adr` out ADDR_W: address of the failing write, 0 for timeout.
- `err_data` out DATA_W: data of the failing write, 0 for timeout.

## Operation
- States are RUN, PASS and FAIL. Reset puts the block in RUN.
- Reset values: all outputs 0; match bitmap 0; cycle counter 0.
- In RUN, a write is an edge where `MemWrite`=1. Each write is classified in this priority order:
  1. **Expected hit.**
     - ORDERED=1: `Adr`==exp_adr[match_cnt] and `WriteData`==exp_data[match_cnt].
     - ORDERED=0: the lowest index i not yet matched with matching address and data.
     - Action: set bitmap bit, increment `match_cnt`.
     - If this makes `match_cnt`==N_EXP, go to PASS.
  2. **Ignore.** `Adr` equals any ign_adr entry. No state change.
  3. **Duplicate** (ORDERED=0 only). Address and data match an already-matched entry. Go to FAIL, code 3.
  4. **Data mismatch.** The address matches the current expected entry (ORDERED=1) or any unmatched entry (ORDERED=0), but the data differs. Go to FAIL, code 2.
  5. **Otherwise:** go to FAIL, code 1.
- ORDERED=1 with a later-index address written early falls under case 5: code 1.
- On any FAIL from a write, capture `Adr` into `err_adr` and `WriteData` into `err_data`.
- Timeout:
  - The cycle counter increments every edge in RUN and saturates.
  - On the edge where the counter equals TIMEOUT-1, if the write on that edge does not cause PASS or FAIL, go to FAIL with code 4.
- PASS and FAIL are sticky. All inputs are ignored until `reset` is asserted. Counters freeze.
- `done` = `pass` | `fail`. `pass` and `fail` are never both 1.
- Comparisons are 2-state `==`. X/Z on the inputs is the bench's responsibility.

## Timing
- Everything is registered. A write sampled at edge k is reflected on `match_cnt`, `pass`, `fail`, `fail_code` and `err_*` immediately after edge k. Latency is 1 edge; there is no combinational path from inputs to outputs.
- Back-to-back writes on consecutive edges are each classified independently. There are no dead cycles.
- Final expected write on the same edge as the timeout: PASS wins.
- Reset asserted mid-run clears all state asynchronously. After release, the check restarts in RUN with counter 0 on the first rising edge.
- `MemWrite`=0 edges change only the cycle counter.

## Test plan
- **Legacy equivalence.** Parameters: N_EXP=1, N_IGN=1, exp=(100,7), ign=96. Stimulus: write (96,3) then (100,7). Required: `pass`=1 one edge after the second write, `match_cnt`=1, `fail_code`=0.
- **Ordered sequence.** Parameters: N_EXP=3, ORDERED=1, exp=(0x10,1),(0x14,2),(0x18,3). Stimulus: write (0x14,2) first. Required: FAIL, code 1, `err_adr`=0x14. Correct order: PASS after the 3rd write with `match_cnt`=3.
- **Unordered and duplicate.** Same expected set, ORDERED=0. Stimulus: (0x18,3),(0x10,1),(0x18,3). Required: FAIL, code 3 on the 3rd write. Stimulus (0x18,3),(0x10,1),(0x14,2) on consecutive edges: PASS.
- **Data mismatch.** ORDERED=1. Stimulus: write (0x10,9). Required: FAIL, code 2, `err_adr`=0x10, `err_data`=9, `match_cnt`=0.
- **Timeout and collision.**
  - TIMEOUT=16, no writes: FAIL code 4 after the 16th edge.
  - Final expected write landing on edge 16: PASS instead.
  - Writes after a terminal state: no output change.
- **Reset mid-run.** Parameters: N_EXP=2. Stimulus: match entry 0, pulse `reset` low between edges, then write entry 1 only. Required: `match_cnt`=0 during reset, FAIL code 1 (ORDERED=1), `err_adr`=exp_adr[1].
